// File: rtl/io_pkg.sv
// Shared types and default widths for the processor IN/OUT device responder.
package io_pkg;

  localparam int IO_DATA_W = 32;
  localparam int IO_SW_W   = 16;

  typedef enum logic [1:0] {
    IO_IDLE       = 2'd0,
    IO_WAIT_ENTER = 2'd1,
    IO_RESPOND    = 2'd2,
    IO_WAIT_DROP  = 2'd3
  } io_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces a raw push button, emitting a one-cycle pulse
// when the accepted (stable) level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d, stable_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn_raw_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/io_responder.sv
// Device side of the processor IN/OUT handshake: answers input requests with
// switch data on an Enter press and latches processor output for the display.
module io_responder
  import io_pkg::*;
#(
  parameter int DATA_W       = IO_DATA_W,
  parameter int SW_W         = IO_SW_W,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_req_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] in_data_o,
  input  logic              new_out_i,
  input  logic [DATA_W-1:0] out_data_i,
  input  logic [SW_W-1:0]   sw_i,
  input  logic              enter_btn_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  output logic              waiting_input_o,
  output logic [7:0]        in_count_o
);

  io_state_e         state_q, state_d;
  logic              press;
  logic              capture;
  logic [DATA_W-1:0] in_data_q;
  logic [7:0]        in_count_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              disp_valid_q;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .btn_raw_i (enter_btn_i),
    .press_o   (press)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IO_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A dropped request takes priority over a press landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IO_IDLE:       if (in_req_i) state_d = IO_WAIT_ENTER;
      IO_WAIT_ENTER: begin
        if (!in_req_i) begin
          state_d = IO_IDLE;
        end else if (press) begin
          state_d = IO_RESPOND;
        end
      end
      IO_RESPOND:    state_d = IO_WAIT_DROP;
      IO_WAIT_DROP:  if (!in_req_i) state_d = IO_IDLE;
      default:       state_d = IO_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o      = (state_q == IO_RESPOND);
    waiting_input_o = (state_q == IO_WAIT_ENTER);
    capture         = (state_q == IO_WAIT_ENTER) && in_req_i && press;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_data_q  <= '0;
      in_count_q <= '0;
    end else begin
      if (capture) begin
        in_data_q <= DATA_W'(sw_i);
      end
      if (state_q == IO_RESPOND) begin
        in_count_q <= in_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else if (new_out_i) begin
      disp_data_q  <= out_data_i;
      disp_valid_q <= 1'b1;
    end
  end

  assign in_data_o    = in_data_q;
  assign in_count_o   = in_count_q;
  assign disp_data_o  = disp_data_q;
  assign disp_valid_o = disp_valid_q;

endmodule
